// File: rtl/mips_dbg_pkg.sv
// Shared debug-path types and defaults for the register-file dumper.
// Holds the dump FSM state encoding and the checksum word address.
package mips_dbg_pkg;

    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_DW    = 32;

    // The checksum word reuses address 0; the host tells it apart by out_last.
    localparam int CSUM_ADDR = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready word stream carrying (address, value) pairs to the debug link.
// master drives a word and holds it until out_ready; slave is the sink.
interface regfile_dumper_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output out_valid, out_addr, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_addr, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dumper.sv
// Walks every register through a read-only port and streams (addr, value) words.
// Latency: first word valid one cycle after the start edge; 2 cycles per word at full rate.
// Backpressure: a word is held stable indefinitely while out_ready is low; the index does not advance.
// Optional REGFILE_DUMPER_CHECKSUM_EN appends a mod-2^DW sum word (addr 0, last=1) after the registers.
module regfile_dumper
    import mips_dbg_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  dbg_ra,
    input  logic [DW-1:0]  dbg_rd,
    regfile_dumper_if.master out
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t   state;
    dump_state_t   state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          last_q;
    logic          xfer;
    logic          at_last;

`ifdef REGFILE_DUMPER_CHECKSUM_EN
    logic [DW-1:0] sum;
`endif

    assign xfer    = out.out_valid && out.out_ready;
    assign at_last = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = SEND;
            SEND: begin
                if (xfer) begin
`ifdef REGFILE_DUMPER_CHECKSUM_EN
                    state_nxt = at_last ? CSUM : READ;
`else
                    state_nxt = at_last ? DONE : READ;
`endif
                end
            end
`ifdef REGFILE_DUMPER_CHECKSUM_EN
            CSUM: if (xfer) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort wins over start and over a handshake in the same cycle
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            addr_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
            sum    <= '0;
`endif
        end else if (abort) begin
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
                        sum <= '0;
`endif
                    end
                end
                READ: begin
                    addr_q <= idx;
                    data_q <= dbg_rd;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
                    last_q <= 1'b0;
`else
                    last_q <= at_last;
`endif
                end
                SEND: begin
                    if (xfer) begin
                        if (!at_last) idx <= idx + AW'(1);
`ifdef REGFILE_DUMPER_CHECKSUM_EN
                        sum <= sum + data_q;
                        if (at_last) begin
                            // Fold the word being accepted straight into the presented sum.
                            addr_q <= AW'(CSUM_ADDR);
                            data_q <= sum + data_q;
                            last_q <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state == READ) || (state == SEND) || (state == CSUM);
    assign done          = (state == DONE);
    assign dbg_ra        = (state == READ) ? idx : '0;
    assign out.out_valid = (state == SEND) || (state == CSUM);
    assign out.out_addr  = addr_q;
    assign out.out_data  = data_q;
    assign out.out_last  = last_q;

endmodule
